data_ram_ctrl: RTL

- Data-memory stage directly downstream of the memory-control stage.
- Consumes the read/write strobe pair, the 4-bit RAM address and the store data; returns load data on the data bus.
- Wraps a 16x32 synchronous RAM with a small FSM that inserts a configurable number of wait states.
- Stalls the core while an access is in flight.

---
 rtl/cpu_mem_pkg.sv | 22 ++
 rtl/ram_array.sv | 51 +++++
 rtl/data_ram_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the data-memory stage: access strobes, widths and FSM states.
package cpu_mem_pkg;

    localparam int RAM_ADDR_W = 4;
    localparam int DATA_W     = 32;

    localparam logic [1:0] RW_NONE = 2'b00;
    localparam logic [1:0] RW_LDR  = 2'b01;
    localparam logic [1:0] RW_STR  = 2'b10;
    localparam logic [1:0] RW_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_e;

    function automatic logic is_access(input logic [1:0] rw);
        return (rw == RW_LDR) || (rw == RW_STR);
    endfunction

endpackage

// File: rtl/ram_array.sv
// DEPTH x 32 storage: synchronous write, registered read that holds its value between reads.
module ram_array
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [RAM_ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // A write coinciding with reset is always dropped so an in-flight store is lost.
    generate
        if (INIT_ZERO) begin : g_clear
            always_ff @(posedge clk_i) begin
                if (srst_i) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_q[i] <= '0;
                    end
                end else if (we_i) begin
                    mem_q[addr_i] <= wdata_i;
                end
            end
        end else begin : g_keep
            always_ff @(posedge clk_i) begin
                if (!srst_i && we_i) begin
                    mem_q[addr_i] <= wdata_i;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram_ctrl.sv
// Data-memory stage: wait-state FSM around a 16x32 RAM that stalls the core per access.
// Optional per-op access counters are enabled with DATA_RAM_ACCESS_CNT_EN.
module data_ram_ctrl
    import cpu_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int DEPTH       = 16,
    parameter int INIT_ZERO   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [1:0]            i_RW,
    input  logic [RAM_ADDR_W-1:0] i_ramaddr,
    input  logic [DATA_W-1:0]     i_databus,
    output logic [DATA_W-1:0]     o_databus,
    output logic                  o_stall,
    output logic                  o_done,
    output logic                  o_err
`ifdef DATA_RAM_ACCESS_CNT_EN
    ,
    output logic [15:0]           o_ldcnt,
    output logic [15:0]           o_stcnt
`endif
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [1:0]              op_q, op_d;
    logic [RAM_ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic                    err_q, err_d;

    logic                    commit;
    logic [1:0]              c_op;
    logic [RAM_ADDR_W-1:0]   c_addr;
    logic [DATA_W-1:0]       c_data;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        commit  = 1'b0;
        c_op    = op_q;
        c_addr  = addr_q;
        c_data  = data_q;
        o_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_access(i_RW)) begin
                    o_stall = 1'b1;
                    op_d    = i_RW;
                    addr_d  = i_ramaddr;
                    data_d  = i_databus;
                    if (WAIT_CYCLES == 0) begin
                        // Zero wait states: commit straight from the bus on the accepting edge.
                        state_d = DONE;
                        commit  = 1'b1;
                        c_op    = i_RW;
                        c_addr  = i_ramaddr;
                        c_data  = i_databus;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end else if (i_RW == RW_ILL) begin
                    err_d = 1'b1;
                end
            end
            WAIT: begin
                o_stall = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= RW_NONE;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    ram_array #(
        .DEPTH     (DEPTH),
        .INIT_ZERO (INIT_ZERO != 0)
    ) u_ram (
        .clk_i   (i_clk),
        .srst_i  (i_rst),
        .we_i    (commit && (c_op == RW_STR)),
        .re_i    (commit && (c_op == RW_LDR)),
        .addr_i  (c_addr),
        .wdata_i (c_data),
        .rdata_o (o_databus)
    );

    assign o_done = (state_q == DONE);
    assign o_err  = err_q;

`ifdef DATA_RAM_ACCESS_CNT_EN
    logic [15:0] ldcnt_q, stcnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ldcnt_q <= '0;
            stcnt_q <= '0;
        end else if (state_q == DONE) begin
            if (op_q == RW_LDR && ldcnt_q != 16'hFFFF) begin
                ldcnt_q <= ldcnt_q + 16'd1;
            end
            if (op_q == RW_STR && stcnt_q != 16'hFFFF) begin
                stcnt_q <= stcnt_q + 16'd1;
            end
        end
    end

    assign o_ldcnt = ldcnt_q;
    assign o_stcnt = stcnt_q;
`endif

endmodule
